// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD frame controller.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_ADDR,
        ST_FETCH,
        ST_DATA,
        ST_GAP
    } state_t;

    // Controller init list, entry 0 first: function set, display on, entry mode, clear.
    localparam logic [7:0][7:0] INIT_CMD = {8'h00, 8'h00, 8'h00, 8'h00,
                                            8'h01, 8'h06, 8'h0C, 8'h38};

    // DDRAM start address of each display line, line 0 first.
    localparam logic [3:0][7:0] LINE_BASE = {8'h54, 8'h14, 8'h40, 8'h00};

    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;

    // Set-DDRAM-address command that moves the cursor to column 0 of a line.
    function automatic logic [7:0] line_addr_cmd(input logic [1:0] line);
        return CMD_SET_DDRAM | LINE_BASE[line];
    endfunction

endpackage

// File: rtl/lcd_gap_timer.sv
// Loadable down-counter measuring the idle gap between refreshed frames.
module lcd_gap_timer #(
    parameter int GAP_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(GAP_CYCLES + 1);

    logic [CNT_W-1:0] count;

    // Load the full gap length, then count down while enabled and stop at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(GAP_CYCLES);
        end else if (enable && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/lcd_frame_ctrl.sv
// Sequencer that initialises the LCD once and then refreshes the character
// frame line by line through the byte write engine.
module lcd_frame_ctrl
    import lcd_pkg::*;
#(
    parameter int LINES       = 2,
    parameter int COLS        = 16,
    parameter int INIT_CMD_NO = 4,
    parameter int GAP_CYCLES  = 1000,
    parameter int ADDR_W      = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              refresh_req,
    input  logic              cont_mode,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic              wr_rs,
    output logic [7:0]        wr_data,
    output logic              init_done,
    output logic              busy,
    output logic              frame_done
);

    localparam int LINE_W = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINES - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
    localparam logic [2:0]        CMD_LAST  = 3'(INIT_CMD_NO - 1);

    state_t            state;
    logic [2:0]        cmd_idx;
    logic [LINE_W-1:0] line;
    logic [LINE_W-1:0] next_line;
    logic [COL_W-1:0]  col;
    logic [COL_W-1:0]  next_col;
    logic [ADDR_W-1:0] next_addr;
    logic              pending;
    logic              xfer;
    logic              last_char;
    logic              gap_load;
    logic              gap_enable;
    logic              gap_expired;
    logic              restart;

    assign xfer       = wr_valid & wr_ready;
    assign last_char  = (line == LINE_LAST) && (col == COL_LAST);
    assign gap_load   = (state == ST_DATA) && xfer && last_char;
    assign gap_enable = (state == ST_GAP);
    assign restart    = (gap_expired && cont_mode) || pending || refresh_req;

    // Frame position following the current character, wrapping to 0/0 after the last one.
    always_comb begin
        next_col  = col + COL_W'(1);
        next_line = line;
        if (col == COL_LAST) begin
            next_col  = '0;
            next_line = (line == LINE_LAST) ? '0 : line + LINE_W'(1);
        end
        next_addr = ADDR_W'(next_line) * ADDR_W'(COLS) + ADDR_W'(next_col);
    end

    lcd_gap_timer #(
        .GAP_CYCLES (GAP_CYCLES)
    ) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (gap_load),
        .enable  (gap_enable),
        .expired (gap_expired)
    );

    // Main sequencer; rd_addr moves to the next character as soon as the current
    // one is captured, so the synchronous buffer has it ready by the end of FETCH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cmd_idx    <= '0;
            line       <= '0;
            col        <= '0;
            rd_addr    <= '0;
            wr_valid   <= 1'b0;
            wr_rs      <= RS_CMD;
            wr_data    <= '0;
            init_done  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            pending    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (refresh_req && busy) begin
                pending <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    state    <= ST_INIT;
                    cmd_idx  <= '0;
                    busy     <= 1'b1;
                    wr_valid <= 1'b1;
                    wr_rs    <= RS_CMD;
                    wr_data  <= INIT_CMD[0];
                end
                ST_INIT: begin
                    if (xfer) begin
                        cmd_idx <= cmd_idx + 3'd1;
                        if (cmd_idx == CMD_LAST) begin
                            init_done <= 1'b1;
                            line      <= '0;
                            col       <= '0;
                            state     <= ST_ADDR;
                            wr_data   <= line_addr_cmd(2'd0);
                        end else begin
                            wr_data <= INIT_CMD[cmd_idx + 3'd1];
                        end
                    end
                end
                ST_ADDR: begin
                    if (xfer) begin
                        state    <= ST_FETCH;
                        wr_valid <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    state    <= ST_DATA;
                    wr_valid <= 1'b1;
                    wr_rs    <= RS_DATA;
                    wr_data  <= rd_data;
                    rd_addr  <= next_addr;
                end
                ST_DATA: begin
                    if (xfer) begin
                        if (col != COL_LAST) begin
                            col      <= next_col;
                            state    <= ST_FETCH;
                            wr_valid <= 1'b0;
                        end else if (line != LINE_LAST) begin
                            col     <= '0;
                            line    <= next_line;
                            state   <= ST_ADDR;
                            wr_rs   <= RS_CMD;
                            wr_data <= line_addr_cmd(2'(next_line));
                        end else begin
                            frame_done <= 1'b1;
                            line       <= '0;
                            col        <= '0;
                            state      <= ST_GAP;
                            wr_valid   <= 1'b0;
                            busy       <= 1'b0;
                        end
                    end
                end
                ST_GAP: begin
                    if (restart) begin
                        state    <= ST_ADDR;
                        line     <= '0;
                        col      <= '0;
                        busy     <= 1'b1;
                        pending  <= 1'b0;
                        wr_valid <= 1'b1;
                        wr_rs    <= RS_CMD;
                        wr_data  <= line_addr_cmd(2'd0);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_frame_ctrl.sv
// Self-checking bench for lcd_frame_ctrl: a transfer-level model of the
// expected byte stream is checked against the write port every cycle.
module tb_lcd_frame_ctrl;

    localparam int LINES       = 2;
    localparam int COLS        = 16;
    localparam int INIT_CMD_NO = 4;
    localparam int GAP_CYCLES  = 10;
    localparam int ADDR_W      = 7;
    localparam int FRAME_XFERS = LINES + LINES * COLS;

    logic              clk;
    logic              rst;
    logic              refresh_req;
    logic              cont_mode;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              wr_valid;
    logic              wr_ready;
    logic              wr_rs;
    logic [7:0]        wr_data;
    logic              init_done;
    logic              busy;
    logic              frame_done;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
        logic       last_frame;
        logic       last_init;
    } xfer_t;

    xfer_t      exp_q[$];
    logic [7:0] frame_mem [2**ADDR_W];
    logic [7:0] exp_init [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
    logic [7:0] exp_base [4] = '{8'h00, 8'h40, 8'h14, 8'h54};

    int         assert_count = 0;
    int         fail_count = 0;
    int         xfer_count = 0;
    int         ready_mode = 0;
    int         low_left = 0;
    int         gap_n;
    int         base_count;
    logic       exp_fd_next = 1'b0;
    logic       exp_init_done = 1'b0;
    logic       stalled_prev = 1'b0;
    logic       stall_rs = 1'b0;
    logic [7:0] stall_data = 8'h00;
    logic [7:0] last_xfer_data = 8'h00;

    lcd_frame_ctrl #(
        .LINES       (LINES),
        .COLS        (COLS),
        .INIT_CMD_NO (INIT_CMD_NO),
        .GAP_CYCLES  (GAP_CYCLES),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .refresh_req (refresh_req),
        .cont_mode   (cont_mode),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_rs       (wr_rs),
        .wr_data     (wr_data),
        .init_done   (init_done),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Frame buffer with a one-cycle synchronous read.
    always @(posedge clk) begin
        rd_data <= frame_mem[rd_addr];
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic enqueue_init();
        for (int i = 0; i < INIT_CMD_NO; i++) begin
            exp_q.push_back('{rs: 1'b0, data: exp_init[i], last_frame: 1'b0,
                              last_init: (i == INIT_CMD_NO - 1)});
        end
    endtask

    task automatic enqueue_frame();
        for (int l = 0; l < LINES; l++) begin
            exp_q.push_back('{rs: 1'b0, data: (8'h80 | exp_base[l]), last_frame: 1'b0,
                              last_init: 1'b0});
            for (int c = 0; c < COLS; c++) begin
                exp_q.push_back('{rs: 1'b1, data: frame_mem[l * COLS + c],
                                  last_frame: ((l == LINES - 1) && (c == COLS - 1)),
                                  last_init: 1'b0});
            end
        end
    endtask

    task automatic apply_stimulus_refresh();
        @(posedge clk);
        #1 refresh_req = 1'b1;
        @(posedge clk);
        #1 refresh_req = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wr_valid && n < 100);
        check_output({tag, " valid seen"}, 32'(wr_valid), 1);
    endtask

    task automatic wait_frame_done(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 2000);
        check_output({tag, " frame_done seen"}, 32'(frame_done), 1);
    endtask

    task automatic check_idle(input string tag);
        repeat (40) @(negedge clk);
        check_output({tag, " busy"}, 32'(busy), 0);
        check_output({tag, " wr_valid"}, 32'(wr_valid), 0);
        check_output({tag, " leftover expected"}, 32'(exp_q.size()), 0);
    endtask

    // Ready generator: always ready, random stalls of 1..5 cycles, or held low.
    initial begin
        wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) begin
                wr_ready = 1'b1;
            end else if (ready_mode == 2) begin
                wr_ready = 1'b0;
            end else if (low_left > 0) begin
                wr_ready = 1'b0;
                low_left--;
            end else begin
                wr_ready = 1'b1;
                if ($urandom_range(0, 1) == 1) low_left = $urandom_range(1, 5);
            end
        end
    end

    // Compare process: stream order, stall stability, frame_done and init_done timing.
    initial begin
        xfer_t item;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
                exp_fd_next   = 1'b0;
                exp_init_done = 1'b0;
                stalled_prev  = 1'b0;
            end else begin
                check_output("frame_done", 32'(frame_done), 32'(exp_fd_next));
                check_output("init_done", 32'(init_done), 32'(exp_init_done));
                if (stalled_prev) begin
                    check_output("stall wr_valid held", 32'(wr_valid), 1);
                    check_output("stall wr_data held", 32'(wr_data), 32'(stall_data));
                    check_output("stall wr_rs held", 32'(wr_rs), 32'(stall_rs));
                end
                stalled_prev = wr_valid && !wr_ready;
                stall_data   = wr_data;
                stall_rs     = wr_rs;
                exp_fd_next  = 1'b0;
                if (wr_valid && wr_ready) begin
                    check_output("transfer expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        item = exp_q.pop_front();
                        check_output("xfer wr_rs", 32'(wr_rs), 32'(item.rs));
                        check_output("xfer wr_data", 32'(wr_data), 32'(item.data));
                        exp_fd_next = item.last_frame;
                        if (item.last_init) exp_init_done = 1'b1;
                    end
                    last_xfer_data = wr_data;
                    xfer_count++;
                end
            end
        end
    end

    initial begin
        rst         = 1'b0;
        refresh_req = 1'b0;
        cont_mode   = 1'b0;
        for (int i = 0; i < 2**ADDR_W; i++) frame_mem[i] = 8'(i + 'h41);

        // Reset state
        repeat (3) @(negedge clk);
        check_output("reset wr_valid", 32'(wr_valid), 0);
        check_output("reset wr_rs", 32'(wr_rs), 0);
        check_output("reset wr_data", 32'(wr_data), 0);
        check_output("reset rd_addr", 32'(rd_addr), 0);
        check_output("reset init_done", 32'(init_done), 0);
        check_output("reset busy", 32'(busy), 0);
        check_output("reset frame_done", 32'(frame_done), 0);

        // Init sequence followed by the first frame
        @(posedge clk);
        #1 rst = 1'b1;
        enqueue_init();
        enqueue_frame();
        wait_valid("init", gap_n);
        check_output("first cmd", 32'(wr_data), 32'h38);
        check_output("first cmd rs", 32'(wr_rs), 0);
        check_output("first cmd busy", 32'(busy), 1);
        wait_frame_done("first frame");
        check_output("first frame last byte", 32'(last_xfer_data), 32'h60);
        check_output("init plus frame transfers", xfer_count, 38);
        check_output("gap busy", 32'(busy), 0);
        check_output("init_done sticky", 32'(init_done), 1);

        // Single refresh with random back-pressure
        repeat (5) @(negedge clk);
        ready_mode = 1;
        base_count = xfer_count;
        enqueue_frame();
        apply_stimulus_refresh();
        wait_frame_done("stalled frame");
        check_output("stalled frame transfers", xfer_count - base_count, FRAME_XFERS);
        ready_mode = 0;
        check_idle("after stalled frame");

        // Three requests mid-frame collapse into one extra frame
        enqueue_frame();
        enqueue_frame();
        apply_stimulus_refresh();
        repeat (5) @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            apply_stimulus_refresh();
            repeat (2) @(posedge clk);
        end
        wait_frame_done("pending frame A");
        wait_frame_done("pending frame B");
        check_idle("after pending");

        // Continuous mode: restart spacing after each frame_done
        for (int k = 0; k < 4; k++) enqueue_frame();
        @(posedge clk);
        #1 cont_mode = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_frame_done("cont frame");
            wait_valid("cont restart", gap_n);
            check_output("cont restart spacing", gap_n, GAP_CYCLES + 1);
            check_output("cont restart cmd", 32'(wr_data), 32'h80);
            check_output("cont restart rs", 32'(wr_rs), 0);
        end
        @(posedge clk);
        #1 cont_mode = 1'b0;
        wait_frame_done("cont last frame");
        check_idle("after cont");

        // Reset while a data byte is stalled, then request during init
        enqueue_frame();
        apply_stimulus_refresh();
        gap_n = 0;
        do begin
            @(negedge clk);
            gap_n++;
        end while (!(wr_valid && wr_rs) && gap_n < 50);
        ready_mode = 2;
        repeat (3) @(negedge clk);
        check_output("stalled data valid", 32'(wr_valid && wr_rs), 1);
        #2 rst = 1'b0;
        #1;
        check_output("async reset wr_valid", 32'(wr_valid), 0);
        check_output("async reset busy", 32'(busy), 0);
        check_output("async reset init_done", 32'(init_done), 0);
        @(posedge clk);
        #1 ready_mode = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        enqueue_init();
        enqueue_frame();
        enqueue_frame();
        wait_valid("re-init", gap_n);
        check_output("re-init first cmd", 32'(wr_data), 32'h38);
        check_output("re-init init_done", 32'(init_done), 0);
        apply_stimulus_refresh();
        wait_frame_done("post-reset frame");
        wait_frame_done("init-request frame");
        check_idle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/lcd_frame_ctrl.md
Name: lcd_frame_ctrl

Overview:
- Parametrised successor to the LCD main sequencer. Runs the controller init command list once, then refreshes a LINES x COLS character frame from a character buffer, line by line.
- Drives the byte-level LCD write engine over a valid/ready handshake. Reads characters from the frame buffer through a synchronous read port with 1-cycle latency.
- Supports single-shot and continuous (timed) refresh, and a pending refresh request.

Parameters:
- LINES, 2: display lines, 1..4.
- COLS, 16: characters per line, 1..20.
- INIT_CMD_NO, 4: number of init commands taken from the package table, 1..8.
- GAP_CYCLES, 1000: idle cycles between frames in continuous mode, >=1.
- ADDR_W, 7: frame buffer address width; must satisfy 2^ADDR_W >= LINES*COLS.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset, asynchronous, active-low.
- refresh_req, in, 1: one-cycle pulse; requests one frame refresh.
- cont_mode, in, 1: 1 = auto-refresh every GAP_CYCLES after each frame.
- rd_addr, out, ADDR_W: frame buffer address = line*COLS + col.
- rd_data, in, 8: character code, valid 1 cycle after rd_addr.
- wr_valid, out, 1: byte request to the write engine.
- wr_ready, in, 1: write engine accepts the byte.
- wr_rs, out, 1: 0 = command, 1 = data.
- wr_data, out, 8: byte to write.
- init_done, out, 1: sticky after the last init command is accepted.
- busy, out, 1: high during any frame or init activity.
- frame_done, out, 1: one-cycle pulse when the last character of a frame is accepted.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - wr_valid, wr_rs, wr_data, rd_addr, init_done, busy, frame_done, pending flag and all counters = 0.
  - Asserting reset mid-transfer drops wr_valid immediately.
- Handshake:
  - A transfer occurs on a clk edge with wr_valid & wr_ready.
  - While wr_valid=1 and wr_ready=0, wr_rs and wr_data are held stable.
  - wr_valid never deasserts without a transfer.
- FSM states: IDLE, INIT, ADDR, FETCH, DATA, GAP.
- IDLE:
  - Entered after reset. Next cycle goes to INIT with cmd_idx=0 and busy=1.
- INIT:
  - wr_valid=1, wr_rs=0, wr_data=INIT_CMD[cmd_idx].
  - On transfer, cmd_idx++.
  - On transfer with cmd_idx==INIT_CMD_NO-1: init_done=1, line=0, col=0, go to ADDR.
- ADDR:
  - wr_valid=1, wr_rs=0, wr_data = 8'h80 | LINE_BASE[line].
  - On transfer go to FETCH.
- FETCH:
  - rd_addr = line*COLS + col, wr_valid=0. Exactly one cycle, then go to DATA.
- DATA:
  - On entry, rd_data is registered into wr_data. wr_rs=1, wr_valid=1.
  - On transfer:
    - col<COLS-1: col++, go to FETCH.
    - else if line<LINES-1: col=0, line++, go to ADDR.
    - else: frame_done pulse, then go to GAP if cont_mode=1 or pending=1, else go to WAIT_IDLE behaviour (GAP with busy=0; see below).
- GAP:
  - Gap counter counts GAP_CYCLES cycles; busy=0 during GAP.
  - Restart the frame (line=0, col=0, busy=1, go to ADDR) when:
    - counter expires and cont_mode=1, or
    - pending=1 (immediately), or
    - refresh_req=1 (immediately).
  - With cont_mode=0 and no request, stays in GAP indefinitely; the counter saturates.
- Pending flag:
  - refresh_req while busy=1 sets pending.
  - Pending clears when a new frame starts.
  - Multiple requests collapse into one.
  - refresh_req during INIT is latched the same way.
- Simultaneous events: refresh_req in the cycle a frame starts is absorbed by that frame and does not set pending.
- Per-frame write sequence: each frame writes exactly LINES address commands and LINES*COLS data bytes, in order.
- Minimum byte spacing: with wr_ready tied to 1, one data byte is written every 2 cycles (FETCH + DATA).
- Width rules:
  - line counter is clog2(LINES) bits, minimum 1.
  - col counter is clog2(COLS) bits, minimum 1.
  - rd_addr multiply is done at ADDR_W width.
- Boundary cases:
  - LINES=1: ADDR is issued once per frame.
  - COLS=1: FETCH/DATA alternate with ADDR for every character.

Decomposition:
- Package lcd_pkg holds:
  - state enum.
  - INIT_CMD table: 8'h38, 8'h0C, 8'h06, 8'h01, remaining entries 8'h00.
  - LINE_BASE table: 8'h00, 8'h40, 8'h14, 8'h54.
  - CMD_SET_DDRAM = 8'h80.
  - Write-type constants RS_CMD=0, RS_DATA=1.
- One sub-module lcd_gap_timer: loadable down-counter with a saturating expire flag, width clog2(GAP_CYCLES+1).

Test Plan:
1. Reset then wr_ready=1 -> exactly 4 command transfers 38,0C,06,01 with wr_rs=0; init_done rises after the 01 transfer; next transfer is 80 with wr_rs=0.
2. LINES=2, COLS=16, buffer[i]=i+8'h41, single refresh -> transfer stream is 80, 41..50, C0, 51..60; frame_done pulses once, on the 60 transfer.
3. wr_ready toggling randomly, low for up to 5 cycles -> wr_data/wr_rs stable while stalled; no byte lost or duplicated versus the expected stream.
4. cont_mode=1, GAP_CYCLES=10 -> next 80 command appears exactly 11 cycles after the frame_done pulse (count GAP plus one restart cycle); repeats for 3 frames.
5. refresh_req pulsed 3 times mid-frame, cont_mode=0 -> exactly one extra frame follows; then the block stays in GAP with busy=0.
6. rst asserted during DATA with wr_valid=1 -> wr_valid=0 asynchronously. After release, init restarts with command 38 and init_done=0.
